pio_sm_exec_ctrl: RTL and testbench

Per-PIO-block controller that sequences the program counters of NUM_SM state machines.
- Generates each SM's penable strobe from a 16.8 fractional clock divider.
- Issues one-cycle pc_reset pulses on restart.
- Arbitrates a single shared immediate-instruction injection port (exec) onto the imm input of the target SM's program counter.
- Sits between the CSR block and the per-SM pc/decode datapath.

---
 rtl/pio_ctrl_pkg.sv | 13 +
 rtl/pio_clkdiv.sv | 49 ++++
 rtl/pio_sm_exec_ctrl.sv | 88 ++++++++
 tb/tb_pio_sm_exec_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pio_ctrl_pkg.sv
// Shared widths and helpers for the PIO state-machine execution controller.
package pio_ctrl_pkg;
    localparam int DIV_INT_W  = 16;
    localparam int DIV_FRAC_W = 8;
    localparam int INSTR_W    = 16;
    localparam int MAX_SM     = 4;
    localparam int CNT_W      = DIV_INT_W + 1;

    // An integer divisor of 0 selects the longest period, 65536 cycles.
    function automatic logic [CNT_W-1:0] div_period(input logic [DIV_INT_W-1:0] div_int);
        return (div_int == '0) ? (CNT_W'(1) << DIV_INT_W) : {1'b0, div_int};
    endfunction
endpackage

// File: rtl/pio_clkdiv.sv
// Single-SM 16.8 clock divider producing the penable strobe.
// Fractional accumulator present only when PIO_CLKDIV_FRAC_EN is defined.
module pio_clkdiv
    import pio_ctrl_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  en_i,
    input  logic                  restart_i,
    input  logic [DIV_INT_W-1:0]  div_int_i,
    input  logic [DIV_FRAC_W-1:0] div_frac_i,
    output logic                  penable_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry;
    logic             reload;

    assign reload    = en_i && (cnt_q == '0);
    assign penable_o = reload;

`ifdef PIO_CLKDIV_FRAC_EN
    logic [DIV_FRAC_W-1:0] facc_q, facc_d;

    assign {carry, facc_d} = {1'b0, facc_q} + {1'b0, div_frac_i};

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)        facc_q <= '0;
        else if (restart_i) facc_q <= '0;
        else if (reload)    facc_q <= facc_d;
    end
`else
    logic unused_frac;
    assign unused_frac = ^div_frac_i;
    assign carry       = 1'b0;
`endif

    // Phase realign wins over both reload and count-down.
    always_comb begin
        cnt_d = cnt_q;
        if (restart_i)   cnt_d = '0;
        else if (reload) cnt_d = div_period(div_int_i) - CNT_W'(1) + CNT_W'(carry);
        else if (en_i)   cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
endmodule

// File: rtl/pio_sm_exec_ctrl.sv
// Per-PIO-block controller: clock dividers, pc reset pulses and the shared
// immediate-exec port. Fractional dividing is enabled by PIO_CLKDIV_FRAC_EN.
module pio_sm_exec_ctrl
    import pio_ctrl_pkg::*;
#(
    parameter int NUM_SM = 4,
    parameter int SM_W   = 2
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [NUM_SM-1:0]            en_mask_i,
    input  logic [NUM_SM-1:0]            restart_i,
    input  logic [NUM_SM-1:0]            clkdiv_restart_i,
    input  logic [NUM_SM*DIV_INT_W-1:0]  div_int_i,
    input  logic [NUM_SM*DIV_FRAC_W-1:0] div_frac_i,
    input  logic [NUM_SM-1:0]            stalled_i,
    input  logic                         exec_valid_i,
    input  logic [SM_W-1:0]              exec_sm_i,
    input  logic [INSTR_W-1:0]           exec_instr_i,
    output logic                         exec_ready_o,
    output logic [NUM_SM-1:0]            penable_o,
    output logic [NUM_SM-1:0]            pc_reset_o,
    output logic [NUM_SM-1:0]            imm_o,
    output logic [INSTR_W-1:0]           imm_instr_o
);
    logic               pending_q, pending_d;
    logic [SM_W-1:0]    sm_q, sm_d;
    logic [INSTR_W-1:0] imm_instr_q, imm_instr_d;
    logic [NUM_SM-1:0]  pc_reset_q;
    logic [NUM_SM-1:0]  target;
    logic               accept, issue, cancel;

    for (genvar g = 0; g < NUM_SM; g++) begin : g_div
        pio_clkdiv u_div (
            .clk_i      (clk_i),
            .reset_i    (reset_i),
            .en_i       (en_mask_i[g]),
            .restart_i  (clkdiv_restart_i[g]),
            .div_int_i  (div_int_i[g*DIV_INT_W +: DIV_INT_W]),
            .div_frac_i (div_frac_i[g*DIV_FRAC_W +: DIV_FRAC_W]),
            .penable_o  (penable_o[g])
        );
    end

    always_comb begin
        target = '0;
        for (int i = 0; i < NUM_SM; i++) begin
            target[i] = pending_q && (sm_q == SM_W'(i));
        end
    end

    // Out-of-range targets are handshaken but never become pending.
    assign accept = exec_valid_i && !pending_q && (32'(exec_sm_i) < NUM_SM);
    assign issue  = |(target & ~stalled_i);
    assign cancel = |(target & restart_i);

    always_comb begin
        pending_d   = pending_q;
        sm_d        = sm_q;
        imm_instr_d = imm_instr_q;
        if (accept) begin
            pending_d   = 1'b1;
            sm_d        = exec_sm_i;
            imm_instr_d = exec_instr_i;
        end else if (issue || cancel) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pending_q   <= 1'b0;
            sm_q        <= '0;
            imm_instr_q <= '0;
            pc_reset_q  <= '0;
        end else begin
            pending_q   <= pending_d;
            sm_q        <= sm_d;
            imm_instr_q <= imm_instr_d;
            pc_reset_q  <= restart_i;
        end
    end

    assign exec_ready_o = !pending_q;
    assign imm_o        = target;
    assign pc_reset_o   = pc_reset_q;
    assign imm_instr_o  = imm_instr_q;
endmodule

// File: tb/tb_pio_sm_exec_ctrl.sv
// Directed bench for pio_sm_exec_ctrl: dividers, exec handshake, restart, async reset.
module tb_pio_sm_exec_ctrl;
    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [3:0]  en_mask_i, restart_i, clkdiv_restart_i, stalled_i;
    logic [63:0] div_int_i;
    logic [31:0] div_frac_i;
    logic        exec_valid_i;
    logic [1:0]  exec_sm_i;
    logic [15:0] exec_instr_i;
    logic        exec_ready_o;
    logic [3:0]  penable_o, pc_reset_o, imm_o;
    logic [15:0] imm_instr_o;

    int n_checks = 0;
    int n_errors = 0;

    pio_sm_exec_ctrl #(.NUM_SM(4), .SM_W(2)) dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .en_mask_i        (en_mask_i),
        .restart_i        (restart_i),
        .clkdiv_restart_i (clkdiv_restart_i),
        .div_int_i        (div_int_i),
        .div_frac_i       (div_frac_i),
        .stalled_i        (stalled_i),
        .exec_valid_i     (exec_valid_i),
        .exec_sm_i        (exec_sm_i),
        .exec_instr_i     (exec_instr_i),
        .exec_ready_o     (exec_ready_o),
        .penable_o        (penable_o),
        .pc_reset_o       (pc_reset_o),
        .imm_o            (imm_o),
        .imm_instr_o      (imm_instr_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    int n_pen;
    int win;

    initial begin
        reset_i          = 1'b1;
        en_mask_i        = 4'b0001;
        restart_i        = '0;
        clkdiv_restart_i = '0;
        stalled_i        = '0;
        div_int_i        = {16'd1, 16'd1, 16'd1, 16'd1};
        div_frac_i       = '0;
        exec_valid_i     = 1'b0;
        exec_sm_i        = '0;
        exec_instr_i     = '0;
        #3;
        chk("rst_penable", 32'(penable_o), 32'h1);
        chk("rst_ready", 32'(exec_ready_o), 32'h1);
        chk("rst_imm", 32'(imm_o), 32'h0);
        chk("rst_pc_reset", 32'(pc_reset_o), 32'h0);
        chk("rst_imm_instr", 32'(imm_instr_o), 32'h0);

        // 1: divide by 1 on SM0 only
        cyc(); cyc();
        reset_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("div1_penable", 32'(penable_o), 32'h1);
        end
        chk("div1_ready", 32'(exec_ready_o), 32'h1);

        // 2: divide by 3, realign, freeze, resume
        cyc();
        div_int_i[15:0]  = 16'd3;
        clkdiv_restart_i = 4'b0001;
        cyc();
        clkdiv_restart_i = '0;
        #1;
        chk("div3_k0", 32'(penable_o[0]), 32'h1);
        for (int k = 1; k < 7; k++) begin
            cyc();
            chk("div3_phase", 32'(penable_o[0]), (k % 3 == 0) ? 32'h1 : 32'h0);
        end
        for (int k = 7; k < 12; k++) begin
            cyc();
            en_mask_i = 4'b0000;
            #1;
            chk("div3_frozen", 32'(penable_o), 32'h0);
        end
        cyc();
        en_mask_i = 4'b0001;
        #1;
        chk("resume_k12", 32'(penable_o[0]), 32'h0);
        cyc();
        chk("resume_k13", 32'(penable_o[0]), 32'h0);
        cyc();
        chk("resume_k14", 32'(penable_o[0]), 32'h1);

        // 3: 2 + 0x80/256 fractional divide
        cyc();
        div_int_i[15:0]  = 16'd2;
        div_frac_i[7:0]  = 8'h80;
        clkdiv_restart_i = 4'b0001;
        cyc();
        clkdiv_restart_i = '0;
        #1;
`ifdef PIO_CLKDIV_FRAC_EN
        win = 25;
`else
        win = 20;
`endif
        n_pen = 0;
        for (int k = 0; k < win; k++) begin
            if (k > 0) cyc();
            if (penable_o[0]) n_pen++;
        end
        chk("frac_count", 32'(n_pen), 32'd10);
        en_mask_i = 4'b0000;

        // 4: unstalled exec to SM2
        cyc();
        exec_valid_i = 1'b1;
        exec_sm_i    = 2'd2;
        exec_instr_i = 16'hE081;
        #1;
        chk("ex4_ready_pre", 32'(exec_ready_o), 32'h1);
        cyc();
        exec_valid_i = 1'b0;
        #1;
        chk("ex4_imm", 32'(imm_o), 32'h4);
        chk("ex4_instr", 32'(imm_instr_o), 32'hE081);
        chk("ex4_ready", 32'(exec_ready_o), 32'h0);
        cyc();
        chk("ex4_imm_done", 32'(imm_o), 32'h0);
        chk("ex4_ready_done", 32'(exec_ready_o), 32'h1);
        chk("ex4_instr_hold", 32'(imm_instr_o), 32'hE081);

        // 5: stalled exec, then restart cancels a pending entry
        cyc();
        exec_valid_i = 1'b1;
        exec_instr_i = 16'hA042;
        stalled_i    = 4'b0100;
        for (int k = 0; k < 4; k++) begin
            cyc();
            exec_valid_i = 1'b0;
            #1;
            chk("ex5_imm_stalled", 32'(imm_o), 32'h4);
            chk("ex5_ready_stalled", 32'(exec_ready_o), 32'h0);
        end
        cyc();
        stalled_i = '0;
        #1;
        chk("ex5_imm_issue", 32'(imm_o), 32'h4);
        chk("ex5_ready_issue", 32'(exec_ready_o), 32'h0);
        cyc();
        chk("ex5_imm_done", 32'(imm_o), 32'h0);
        chk("ex5_instr", 32'(imm_instr_o), 32'hA042);

        exec_valid_i = 1'b1;
        exec_instr_i = 16'h1234;
        stalled_i    = 4'b0100;
        cyc();
        exec_valid_i = 1'b0;
        #1;
        chk("rs_pending", 32'(imm_o), 32'h4);
        cyc();
        restart_i = 4'b0100;
        #1;
        chk("rs_pc_reset_pre", 32'(pc_reset_o), 32'h0);
        cyc();
        restart_i = '0;
        #1;
        chk("rs_imm_cleared", 32'(imm_o), 32'h0);
        chk("rs_pc_reset", 32'(pc_reset_o), 32'h4);
        chk("rs_ready", 32'(exec_ready_o), 32'h1);
        cyc();
        chk("rs_pc_reset_end", 32'(pc_reset_o), 32'h0);
        stalled_i = '0;

        // 6: accept plus same-SM restart, then async reset mid-divide
        en_mask_i = 4'b0001;
        cyc();
        div_int_i[15:0]  = 16'd3;
        div_frac_i[7:0]  = 8'h00;
        clkdiv_restart_i = 4'b0001;
        cyc();
        clkdiv_restart_i = '0;
        #1;
        chk("r6_k0", 32'(penable_o[0]), 32'h1);
        cyc();
        exec_valid_i = 1'b1;
        exec_sm_i    = 2'd1;
        exec_instr_i = 16'hBEEF;
        stalled_i    = 4'b0010;
        restart_i    = 4'b0010;
        cyc();
        exec_valid_i = 1'b0;
        restart_i    = '0;
        #1;
        chk("r6_set_wins", 32'(imm_o), 32'h2);
        chk("r6_pc_reset", 32'(pc_reset_o), 32'h2);
        chk("r6_mid_divide", 32'(penable_o[0]), 32'h0);
        reset_i = 1'b1;
        #1;
        chk("r6_imm", 32'(imm_o), 32'h0);
        chk("r6_pc_reset_clr", 32'(pc_reset_o), 32'h0);
        chk("r6_ready", 32'(exec_ready_o), 32'h1);
        chk("r6_penable", 32'(penable_o), 32'h1);
        chk("r6_instr", 32'(imm_instr_o), 32'h0);
        cyc();
        reset_i = 1'b0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
